// File: rtl/mac_pkg.sv
// Shared MAC datapath definitions: default adder geometry, operation
// encoding, default-width stage payload and a geometry legality check.
package mac_pkg;

  localparam int unsigned MAC_WIDTH  = 32;
  localparam int unsigned MAC_STAGES = 4;
  localparam int unsigned MAC_CW     = MAC_WIDTH / MAC_STAGES;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } mac_op_e;

  // Stage payload at the default geometry; the adder re-declares it at its own width.
  typedef struct packed {
    logic                 valid;
    logic [MAC_WIDTH-1:0] a;
    logic [MAC_WIDTH-1:0] b;
    logic [MAC_WIDTH-1:0] s;
    logic                 carry;
  } mac_stage_t;

  function automatic bit chunk_cfg_ok(input int unsigned width, input int unsigned stages);
    return (stages >= 1) && (stages <= width) && ((width % stages) == 0);
  endfunction

endpackage

// File: rtl/FullAdder.sv
// Single-bit full adder cell used to build the ripple chunks.
module FullAdder (
  input  logic i_a,
  input  logic i_b,
  input  logic i_c,
  output logic o_s,
  output logic o_c
);

  logic w_p;

  assign w_p = i_a ^ i_b;
  assign o_s = w_p ^ i_c;
  assign o_c = (i_a & i_b) | (i_c & w_p);

endmodule

// File: rtl/chunk_ripple_adder.sv
// CW-bit ripple chain of FullAdder cells; also exposes the carry into the
// MSB so the caller can form signed overflow.
module chunk_ripple_adder #(
  parameter int unsigned CW = 8
) (
  input  logic [CW-1:0] i_a,
  input  logic [CW-1:0] i_b,
  input  logic          i_carry,
  output logic [CW-1:0] o_sum,
  output logic          o_carry,
  output logic          o_carry_msb
);

  // Each bit owns its carry net so the chain is not one self-dependent vector.
  for (genvar i = 0; i < CW; i++) begin : g_bit
    logic w_ci;
    logic w_co;

    if (i == 0) begin : g_lsb
      assign w_ci = i_carry;
    end else begin : g_mid
      assign w_ci = g_bit[i-1].w_co;
    end

    FullAdder u_fa (
      .i_a (i_a[i]),
      .i_b (i_b[i]),
      .i_c (w_ci),
      .o_s (o_sum[i]),
      .o_c (w_co)
    );
  end

  assign o_carry     = g_bit[CW-1].w_co;
  assign o_carry_msb = g_bit[CW-1].w_ci;

endmodule

// File: rtl/pipelined_chunk_adder.sv
// Pipelined adder/subtractor: one CW-bit ripple chunk per stage with the
// inter-chunk carry registered, valid/ready handshake with bubble collapse.
module pipelined_chunk_adder
  import mac_pkg::*;
#(
  parameter int unsigned WIDTH  = MAC_WIDTH,
  parameter int unsigned STAGES = MAC_STAGES
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] augend_i,
  input  logic [WIDTH-1:0] addend_i,
  input  logic             carry_i,
  input  logic             sub_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             carry_o,
  output logic             overflow_o
);

  localparam int unsigned CW   = WIDTH / STAGES;
  localparam int unsigned LAST = STAGES - 1;

  if (!chunk_cfg_ok(WIDTH, STAGES)) begin : g_cfg_err
    $error("pipelined_chunk_adder: WIDTH must be a nonzero multiple of STAGES");
  end

  typedef struct packed {
    logic             valid;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] s;
    logic             carry;
  } stage_t;

  mac_op_e          w_op;
  logic [WIDTH-1:0] w_b_prep;
  logic             w_c0;
  logic [STAGES:0]  w_en;
  stage_t           w_in   [STAGES];
  logic [CW-1:0]    w_sum  [STAGES];
  logic [STAGES-1:0] w_cout;
  logic [STAGES-1:0] w_cmsb;
  logic             w_unused;

  stage_t           r_st   [STAGES];
  logic             r_ovf;

  assign w_op = mac_op_e'(sub_i);

  always_comb begin
    w_b_prep = addend_i;
    w_c0     = carry_i;
    if (w_op == OP_SUB) begin
      w_b_prep = ~addend_i;
      w_c0     = 1'b1;
    end
  end

  // Enable chain runs from the output back to the input; a stage may load
  // whenever it is empty or the stage after it is moving.
  always_comb begin
    w_en         = '0;
    w_en[STAGES] = ready_i;
    for (int unsigned k = STAGES; k > 0; k--) begin
      w_en[k-1] = ~r_st[k-1].valid | w_en[k];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (k == 0) begin : g_first
      assign w_in[0] = '{valid: valid_i & w_en[0],
                         a:     augend_i,
                         b:     w_b_prep,
                         s:     '0,
                         carry: w_c0};
    end else begin : g_next
      assign w_in[k] = r_st[k-1];
    end

    chunk_ripple_adder #(
      .CW (CW)
    ) u_chunk (
      .i_a         (w_in[k].a[k*CW +: CW]),
      .i_b         (w_in[k].b[k*CW +: CW]),
      .i_carry     (w_in[k].carry),
      .o_sum       (w_sum[k]),
      .o_carry     (w_cout[k]),
      .o_carry_msb (w_cmsb[k])
    );
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        r_st[k] <= '0;
      end
      r_ovf <= 1'b0;
    end else begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        if (w_en[k]) begin
          r_st[k].valid <= w_in[k].valid;
          r_st[k].a     <= w_in[k].a;
          r_st[k].b     <= w_in[k].b;
          // Lower chunks pass through; this stage's chunk is overwritten.
          r_st[k].s                <= w_in[k].s;
          r_st[k].s[k*CW +: CW]    <= w_sum[k];
          r_st[k].carry            <= w_cout[k];
        end
      end
      if (w_en[LAST]) begin
        r_ovf <= w_cmsb[LAST] ^ w_cout[LAST];
      end
    end
  end

  assign w_unused   = ^{r_st[LAST].a, r_st[LAST].b};

  assign ready_o    = w_en[0];
  assign valid_o    = r_st[LAST].valid;
  assign sum_o      = r_st[LAST].s;
  assign carry_o    = r_st[LAST].carry;
  assign overflow_o = r_ovf;

endmodule

// File: tb/tb_pipelined_chunk_adder.sv
// Self-checking bench for pipelined_chunk_adder (WIDTH=32, STAGES=4):
// table vectors, stall, async reset and random traffic through a scoreboard.
module tb_pipelined_chunk_adder;

  localparam int W = 32;
  localparam int S = 4;

  logic         clk_i = 1'b0;
  logic         rst_ni = 1'b0;
  logic         valid_i = 1'b0;
  logic         ready_o;
  logic [W-1:0] augend_i = '0;
  logic [W-1:0] addend_i = '0;
  logic         carry_i = 1'b0;
  logic         sub_i = 1'b0;
  logic         valid_o;
  logic         ready_i = 1'b0;
  logic [W-1:0] sum_o;
  logic         carry_o;
  logic         overflow_o;

  pipelined_chunk_adder #(
    .WIDTH  (W),
    .STAGES (S)
  ) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .valid_i    (valid_i),
    .ready_o    (ready_o),
    .augend_i   (augend_i),
    .addend_i   (addend_i),
    .carry_i    (carry_i),
    .sub_i      (sub_i),
    .valid_o    (valid_o),
    .ready_i    (ready_i),
    .sum_o      (sum_o),
    .carry_o    (carry_o),
    .overflow_o (overflow_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [W+1:0] exp;
    int           cyc;
  } sb_t;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         c;
    logic         s;
    logic [W+1:0] exp;  // {overflow, carry, sum}
  } vec_t;

  sb_t  sb[$];
  sb_t  mon_e;
  vec_t tbl[10];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  bit   chk_lat = 1'b0;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic c, input logic s);
    logic [W-1:0] bb;
    logic         c0;
    logic [W:0]   full;
    logic         ovf;
    bb   = s ? ~b : b;
    c0   = s ? 1'b1 : c;
    full = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, c0};
    ovf  = (a[W-1] == bb[W-1]) && (full[W-1] != a[W-1]);
    return {ovf, full[W], full[W-1:0]};
  endfunction

  always @(negedge clk_i) begin
    if (rst_ni && valid_o === 1'b1 && ready_i === 1'b1) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_output: got %0h want none", {overflow_o, carry_o, sum_o});
      end else begin
        mon_e = sb.pop_front();
        chk("result", {30'd0, overflow_o, carry_o, sum_o}, {30'd0, mon_e.exp});
        if (chk_lat) chk("latency", 64'(cyc - mon_e.cyc), 64'(S));
      end
    end
  end

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                      input logic s, input logic [W+1:0] exp, input logic rdy);
    bit acc;
    acc = 1'b0;
    @(posedge clk_i); #1;
    augend_i = a; addend_i = b; carry_i = c; sub_i = s; valid_i = 1'b1; ready_i = rdy;
    for (int n = 0; n < 50 && !acc; n++) begin
      @(negedge clk_i);
      if (ready_o === 1'b1) begin
        sb.push_back('{exp: exp, cyc: cyc});
        acc = 1'b1;
      end else begin
        @(posedge clk_i); #1;
        ready_i = 1'b1;
      end
    end
    if (!acc) begin
      total++;
      bad++;
      $display("FAIL send_timeout: got ready_o=%b want 1", ready_o);
    end
  endtask

  task automatic idle();
    @(posedge clk_i); #1;
    valid_i = 1'b0;
  endtask

  task automatic drain();
    for (int n = 0; n < 60 && sb.size() != 0; n++) @(negedge clk_i);
    chk("drain_empty", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    logic [W+1:0] snap;
    logic [W-1:0] ra, rb;
    logic         rc, rs;
    int           stale;

    tbl[0] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, {1'b0, 1'b1, 32'h0000_0000}};
    tbl[1] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, {1'b1, 1'b0, 32'h8000_0000}};
    tbl[2] = '{32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, {1'b0, 1'b0, 32'hFFFF_FFFE}};
    tbl[3] = '{32'h0000_0007, 32'h0000_0005, 1'b0, 1'b1, {1'b0, 1'b1, 32'h0000_0002}};
    tbl[4] = '{32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0, {1'b0, 1'b0, 32'h0000_0001}};
    tbl[5] = '{32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, {1'b1, 1'b1, 32'h7FFF_FFFF}};
    tbl[6] = '{32'h1234_5678, 32'h0FED_CBA9, 1'b0, 1'b0, {1'b0, 1'b0, 32'h2222_2221}};
    tbl[7] = '{32'h0000_FFFF, 32'h0000_FFFF, 1'b1, 1'b0, {1'b0, 1'b0, 32'h0001_FFFF}};
    tbl[8] = '{32'h0000_0000, 32'h0000_0000, 1'b1, 1'b1, {1'b0, 1'b1, 32'h0000_0000}};
    tbl[9] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, {1'b1, 1'b1, 32'h0000_0000}};

    // Reset state
    ready_i = 1'b1;
    repeat (2) @(negedge clk_i);
    chk("reset_state", {28'd0, valid_o, ready_o, carry_o, overflow_o, sum_o},
        {28'd0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0});
    rst_ni = 1'b1;

    // Back-to-back table vectors with fixed latency
    chk_lat = 1'b1;
    foreach (tbl[i]) send(tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].s, tbl[i].exp, 1'b1);
    idle();
    drain();
    chk_lat = 1'b0;

    // Fill the pipe under backpressure and hold it
    for (int i = 0; i < S; i++) begin
      ra = $urandom; rb = $urandom; rc = 1'($urandom_range(0, 1)); rs = 1'($urandom_range(0, 1));
      send(ra, rb, rc, rs, model(ra, rb, rc, rs), 1'b0);
    end
    idle();
    @(negedge clk_i);
    chk("stall_full", {62'd0, ready_o, valid_o}, {62'd0, 1'b0, 1'b1});
    snap = {overflow_o, carry_o, sum_o};
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_i);
      chk("stall_hold", {29'd0, valid_o, ready_o, overflow_o, carry_o, sum_o},
          {29'd0, 1'b1, 1'b0, snap});
    end

    // Release while offering a new item: accept and drain in one cycle
    @(posedge clk_i); #1;
    ra = 32'hDEAD_BEEF; rb = 32'h2152_4111;
    augend_i = ra; addend_i = rb; carry_i = 1'b1; sub_i = 1'b0;
    valid_i = 1'b1; ready_i = 1'b1;
    @(negedge clk_i);
    chk("full_accept", {63'd0, ready_o}, 64'd1);
    if (ready_o === 1'b1) sb.push_back('{exp: model(ra, rb, 1'b1, 1'b0), cyc: cyc});
    idle();
    drain();

    // Asynchronous reset with items in flight
    for (int i = 0; i < S; i++) begin
      ra = $urandom; rb = $urandom;
      send(ra, rb, 1'b0, 1'b0, model(ra, rb, 1'b0, 1'b0), 1'b0);
    end
    idle();
    @(negedge clk_i);
    chk("pre_reset_valid", {63'd0, valid_o}, 64'd1);
    #2;
    rst_ni = 1'b0;
    #1;
    chk("async_reset", {29'd0, valid_o, ready_o, carry_o, overflow_o, sum_o},
        {29'd0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0});
    sb.delete();
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    ready_i = 1'b1;
    stale = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_i);
      if (valid_o !== 1'b0) stale++;
    end
    chk("no_stale", 64'(stale), 64'd0);
    chk_lat = 1'b1;
    send(tbl[1].a, tbl[1].b, tbl[1].c, tbl[1].s, tbl[1].exp, 1'b1);
    idle();
    drain();
    chk_lat = 1'b0;

    // Random traffic with random backpressure
    for (int i = 0; i < 24; i++) begin
      ra = $urandom; rb = $urandom; rc = 1'($urandom_range(0, 1)); rs = 1'($urandom_range(0, 1));
      send(ra, rb, rc, rs, model(ra, rb, rc, rs), 1'($urandom_range(0, 1)));
    end
    idle();
    ready_i = 1'b1;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
